// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: NOP encoding, fetch FSM states, default memory span
// and the PC legality rule used by the fetch stage.
package mips_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES_DEFAULT = 128;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFault = 2'd2
    } fetch_state_e;

    // A PC is fetchable when word aligned and the whole word lies inside memory.
    function automatic logic pc_is_legal(input logic [31:0] pc, input logic [31:0] last_pc);
        return (pc[1:0] == 2'b00) && (pc <= last_pc);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Squash has priority over load and inserts a NOP bubble;
// with neither asserted the register holds.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        squash_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else if (squash_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, BOOT/RUN/FAULT control, delivered-instruction counter,
// and the IF/ID register fed straight from the combinational instruction memory.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o,
    output logic        fault_o,
    output logic [15:0] fetch_count_o
);

    localparam logic [31:0] LastPc = 32'(IMEM_BYTES - 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [15:0]  count_q, count_d;
    logic [31:0]  pc_plus4;
    logic         pc_legal;
    logic         ifid_load;
    logic         ifid_squash;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_legal = pc_is_legal(pc_q, LastPc);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: begin
                state_d = pc_is_legal(RESET_PC, LastPc) ? StRun : StFault;
            end
            StRun: begin
                if (!branch_taken_i && !stall_i && !pc_legal) begin
                    state_d = StFault;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase
    end

    // Output / datapath control
    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;
        unique case (state_q)
            StRun: begin
                if (branch_taken_i) begin
                    pc_d        = branch_target_i;
                    ifid_squash = 1'b1;
                end else if (stall_i) begin
                    // Everything holds.
                end else if (!pc_legal) begin
                    ifid_squash = 1'b1;
                end else begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            default: begin
                ifid_squash = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ifid_load),
        .squash_i   (ifid_squash),
        .instr_i    (imem_data_i),
        .pc_plus4_i (pc_plus4),
        .instr_o    (if_id_instr_o),
        .pc_plus4_o (if_id_pc_plus4_o),
        .valid_o    (if_id_valid_o)
    );

    assign imem_addr_o   = pc_q;
    assign fault_o       = (state_q == StFault);
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// stall/branch traffic compared against a cycle-level behavioural model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
    logic [15:0] count;

    logic [31:0] mem [0:31];
    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fault, m_boot;
    int unsigned m_count;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'hBAD0_BAD0;

    instruction_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .branch_taken_i   (br),
        .branch_target_i  (target),
        .imem_addr_o      (imem_addr),
        .imem_data_i      (imem_data),
        .if_id_instr_o    (instr),
        .if_id_pc_plus4_o (pc4),
        .if_id_valid_o    (valid),
        .fault_o          (fault),
        .fetch_count_o    (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change only in the window just after a rising edge.
    task automatic reset_pulse();
        rst = 1'b1;
        stall = 1'b0;
        br = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    function automatic bit legal(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc <= 32'd124);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[pc / 4];
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1; m_count = 0;
    endtask

    // One clock of the fetch rules, from the inputs present before the edge.
    task automatic model_step();
        if (m_fault) begin
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (!legal(32'h0)) m_fault = 1'b1;
        end else if (br) begin
            m_pc = target; m_instr = 32'h0; m_valid = 1'b0;
        end else if (stall) begin
        end else if (!legal(m_pc)) begin
            m_fault = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = word_at(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
            if (m_count < 65535) m_count++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
        n_checks++; if (pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", pc4); end
        n_checks++; if (valid !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_flags got v=%b f=%b want 0 0", valid, fault); end
        n_checks++; if (count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        tick();
        n_checks++; if (imem_addr !== 32'h0 || valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold got addr=%h v=%b want 0 0", imem_addr, valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_i [3];
        exp_i[0] = 32'hA00000AA; exp_i[1] = 32'h10000011; exp_i[2] = 32'h20000022;
        reset_pulse();
        tick();
        n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL boot got v=%b addr=%h want 0 0", valid, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (instr !== exp_i[i] || pc4 !== 32'(4 * (i + 1)) || valid !== 1'b1 || count !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL seq_fetch%0d got %h/%h v=%b n=%0d want %h/%h v=1 n=%0d",
                         i, instr, pc4, valid, count, exp_i[i], 32'(4 * (i + 1)), i + 1);
            end
        end
    endtask

    task automatic test_stall();
        reset_pulse();
        tick(); tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (instr !== 32'h10000011 || pc4 !== 32'h8 || imem_addr !== 32'h8 || count !== 16'd2) begin
                n_fail++;
                $display("FAIL stall_hold%0d got %h/%h pc=%h n=%0d want 10000011/8 pc=8 n=2", i, instr, pc4, imem_addr, count);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (instr !== 32'h20000022 || pc4 !== 32'hC || count !== 16'd3) begin n_fail++; $display("FAIL stall_resume got %h/%h n=%0d want 20000022/c n=3", instr, pc4, count); end
    endtask

    task automatic test_branch_stall();
        stall = 1'b1; br = 1'b1; target = 32'h20;
        tick();
        stall = 1'b0; br = 1'b0;
        n_checks++; if (valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h20 || count !== 16'd3) begin n_fail++; $display("FAIL branch_squash got v=%b %h pc=%h n=%0d want v=0 0 pc=20 n=3", valid, instr, imem_addr, count); end
        tick();
        n_checks++; if (valid !== 1'b1 || instr !== mem[8] || pc4 !== 32'h24 || count !== 16'd4) begin n_fail++; $display("FAIL branch_fetch got v=%b %h/%h n=%0d want v=1 %h/24 n=4", valid, instr, pc4, count, mem[8]); end
    endtask

    task automatic test_misaligned_branch();
        br = 1'b1; target = 32'h82;
        tick();
        br = 1'b0;
        n_checks++; if (imem_addr !== 32'h82 || fault !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL misalign_accept got pc=%h f=%b v=%b want 82 0 0", imem_addr, fault, valid); end
        tick();
        n_checks++; if (fault !== 1'b1 || valid !== 1'b0 || imem_addr !== 32'h82 || instr !== 32'h0) begin n_fail++; $display("FAIL misalign_fault got f=%b v=%b pc=%h %h want 1 0 82 0", fault, valid, imem_addr, instr); end
        br = 1'b1; target = 32'h0; stall = 1'b1;
        tick(); tick();
        br = 1'b0; stall = 1'b0;
        n_checks++; if (fault !== 1'b1 || imem_addr !== 32'h82 || valid !== 1'b0) begin n_fail++; $display("FAIL fault_sticky got f=%b pc=%h v=%b want 1 82 0", fault, imem_addr, valid); end
    endtask

    task automatic test_end_of_memory();
        reset_pulse();
        tick();
        br = 1'b1; target = 32'h78;
        tick();
        br = 1'b0;
        tick();
        tick();
        n_checks++; if (instr !== mem[31] || pc4 !== 32'h80 || valid !== 1'b1 || imem_addr !== 32'h80 || fault !== 1'b0) begin n_fail++; $display("FAIL last_word got %h/%h v=%b pc=%h f=%b want %h/80 v=1 pc=80 f=0", instr, pc4, valid, imem_addr, fault, mem[31]); end
        tick();
        n_checks++; if (fault !== 1'b1 || imem_addr !== 32'h80 || valid !== 1'b0 || count !== 16'd2) begin n_fail++; $display("FAIL range_fault got f=%b pc=%h v=%b n=%0d want 1 80 0 2", fault, imem_addr, valid, count); end
    endtask

    task automatic test_reset_midrun();
        reset_pulse();
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (count !== 16'd5) begin n_fail++; $display("FAIL midrun_count got %0d want 5", count); end
        stall = 1'b1; br = 1'b1; target = 32'h40;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (imem_addr !== 32'h0 || instr !== 32'h0 || pc4 !== 32'h0 || valid !== 1'b0 || fault !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL async_reset got pc=%h %h/%h v=%b f=%b n=%0d want all 0", imem_addr, instr, pc4, valid, fault, count); end
        tick();
        stall = 1'b0; br = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL reboot got v=%b pc=%h want 0 0", valid, imem_addr); end
        tick();
        n_checks++; if (instr !== 32'hA00000AA || pc4 !== 32'h4 || count !== 16'd1) begin n_fail++; $display("FAIL resume got %h/%h n=%0d want a00000aa/4 n=1", instr, pc4, count); end
    endtask

    task automatic test_random();
        reset_pulse();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) target = ($urandom_range(0, 1) == 0) ? 32'h80 : 32'h2A;
            else target = 32'($urandom_range(0, 31)) * 4;
            model_step();
            tick();
            n_checks++;
            if (imem_addr !== m_pc || instr !== m_instr || valid !== m_valid || fault !== m_fault ||
                count !== 16'(m_count) || (m_valid && pc4 !== m_pc4)) begin
                n_fail++;
                $display("FAIL random_c%0d got pc=%h %h/%h v=%b f=%b n=%0d want pc=%h %h/%h v=%b f=%b n=%0d",
                         c, imem_addr, instr, pc4, valid, fault, count,
                         m_pc, m_instr, m_pc4, m_valid, m_fault, m_count);
            end
            if (m_fault && $urandom_range(0, 5) == 0) begin
                reset_pulse();
                model_reset();
            end
        end
        stall = 1'b0; br = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'hA00000AA;
        mem[1] = 32'h10000011;
        mem[2] = 32'h20000022;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_misaligned_branch();
        test_end_of_memory();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, byte address loaded into PC at reset.
REQ-002 Parameter IMEM_BYTES, default 128, byte span of instruction memory; legal fetch PCs are 0..IMEM_BYTES-4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID register (load-use hazard from ID).
REQ-006 branch_taken  input  1  redirect fetch to branch_target and squash the fetched instruction.
REQ-007 branch_target  input  32  redirect byte address.
REQ-008 imem_addr  output  32  byte address to instruction memory; equals PC combinationally.
REQ-009 imem_data  input  32  instruction word returned combinationally by instruction memory in the same cycle.
REQ-010 if_id_instr  output  32  registered instruction to ID.
REQ-011 if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-012 if_id_valid  output  1  if_id_instr is a real fetched instruction, not a bubble.
REQ-013 fault  output  1  sticky fetch fault (out-of-range or misaligned PC).
REQ-014 fetch_count  output  16  number of instructions delivered with if_id_valid=1, saturating.

Function
REQ-015 States: BOOT, RUN, FAULT; reset enters BOOT.
REQ-016 BOOT lasts exactly one cycle after reset deassertion: PC holds RESET_PC, if_id_valid=0; next state RUN unless RESET_PC is illegal, then FAULT.
REQ-017 RUN, priority branch_taken > stall > normal fetch.
REQ-018 Normal fetch: if_id_instr<=imem_data, if_id_pc_plus4<=PC+4, if_id_valid<=1, PC<=PC+4, fetch_count increments; one-cycle latency from imem_addr to IF/ID.
REQ-019 stall (branch_taken=0): PC, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count all hold.
REQ-020 branch_taken (regardless of stall): PC<=branch_target, if_id_instr<=NOP (32'h00000000), if_id_valid<=0, fetch_count holds.
REQ-021 PC is legal iff PC[1:0]==2'b00 and PC<=IMEM_BYTES-4; checks apply to the PC being fetched.
REQ-022 Illegal PC in RUN on a non-stalled, non-branch cycle: next state FAULT, IF/ID loads NOP with valid=0, PC holds.
REQ-023 Illegal branch_target is accepted into PC; the fault is raised on the following fetch cycle per REQ-022.
REQ-024 FAULT: fault=1, if_id_valid=0, if_id_instr=NOP, PC frozen, stall/branch ignored; exit only via rst.
REQ-025 PC+4 is 32-bit modulo arithmetic; the range check precludes wrap-around fetches.
REQ-026 fetch_count saturates at 16'hFFFF and never wraps.

Reset
REQ-027 rst asserted at any time, including mid-stall or mid-branch, immediately forces PC=RESET_PC, if_id_instr=NOP, if_id_pc_plus4=0, if_id_valid=0, fault=0, fetch_count=0, state=BOOT.
REQ-028 imem_addr reflects RESET_PC while rst is asserted.

Structure
REQ-029 A shared package mips_pkg holds the NOP constant, the fetch state encoding (BOOT/RUN/FAULT), and the IMEM_BYTES default.
REQ-030 The IF/ID pipeline register (instr, pc_plus4, valid with load/hold/squash controls) is one sub-module named if_id_reg; PC, state machine, and counter stay in instruction_fetch.

Verification
REQ-031 Memory model preloaded 0:A00000AA, 4:10000011, 8:20000022; release rst, no stall -> cycle after BOOT if_id_instr=A00000AA with pc_plus4=4, then 10000011/8, 20000022/12, fetch_count=3.
REQ-032 Stall asserted 2 cycles while IF/ID holds 10000011 -> IF/ID and PC unchanged for 2 cycles; next cycle 20000022 delivered; fetch_count unchanged during stall.
REQ-033 branch_taken=1 with branch_target=0x20 and stall=1 in the same cycle -> next cycle if_id_valid=0, instr=NOP, PC=0x20; following cycle delivers the word at 0x20 with pc_plus4=0x24.
REQ-034 branch_target=0x82 (misaligned) -> one cycle later fault=1, if_id_valid=0, PC frozen at 0x82; a later branch to 0x0 is ignored until rst.
REQ-035 Sequential fetch reaching PC=0x7C then 0x80 -> 0x7C delivered valid, then fault=1 with PC held at 0x80.
REQ-036 rst pulsed mid-run with fetch_count=5 -> all outputs return to reset values asynchronously, and fetch resumes at RESET_PC after the one-cycle BOOT.
